// File: rtl/mem_port_arbiter.sv
// Shares one unified memory port between instruction fetch and data memory.
// DM has priority; a fairness guard, fence blocking and a hung-access timeout.
module mem_port_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int FAIR_LIMIT  = 4,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_if_req,
   input  logic [ADDR_W-1:0]   i_if_addr,
   output logic                o_if_ack,
   output logic [DATA_W-1:0]   o_if_rdata,
   output logic                o_if_err,
   input  logic                i_dm_req,
   input  logic                i_dm_we,
   input  logic [ADDR_W-1:0]   i_dm_addr,
   input  logic [DATA_W-1:0]   i_dm_wdata,
   input  logic [DATA_W/8-1:0] i_dm_be,
   output logic                o_dm_ack,
   output logic [DATA_W-1:0]   o_dm_rdata,
   output logic                o_dm_err,
   input  logic                i_fence,
   output logic                o_mem_req,
   output logic                o_mem_we,
   output logic [ADDR_W-1:0]   o_mem_addr,
   output logic [DATA_W-1:0]   o_mem_wdata,
   output logic [DATA_W/8-1:0] o_mem_be,
   input  logic                i_mem_ack,
   input  logic [DATA_W-1:0]   i_mem_rdata,
   output logic                o_stall_if,
   output logic                o_stall_dm
);

   localparam int BE_W = DATA_W / 8;
   localparam int FC_W = $clog2(FAIR_LIMIT + 1);
   localparam int TC_W = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_IF = 2'd1,
      BUSY_DM = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [FC_W-1:0]     fair_q, fair_d;
   logic [TC_W-1:0]     tmo_q, tmo_d;

   logic                mem_req_d, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_d;
   logic [BE_W-1:0]     mem_be_d;
   logic                if_ack_d, if_err_d;
   logic [DATA_W-1:0]   if_rdata_d;
   logic                dm_ack_d, dm_err_d;
   logic [DATA_W-1:0]   dm_rdata_d;

   logic                if_elig, dm_elig;
   logic                fair_full, tmo_hit;
   logic                done;
   logic [DATA_W-1:0]   done_data;

   // A requester whose ack pulses this cycle still holds its request; mask it.
   assign if_elig   = i_if_req & ~i_fence & ~o_if_ack;
   assign dm_elig   = i_dm_req & ~o_dm_ack;
   assign fair_full = (fair_q >= FC_W'(FAIR_LIMIT));
   assign tmo_hit   = (tmo_q == TC_W'(TIMEOUT_CYC - 1));

   assign o_stall_if = i_if_req & ~o_if_ack;
   assign o_stall_dm = i_dm_req & ~o_dm_ack;

   // Next-state, grant selection, completion/abort and counter updates.
   always_comb begin
      state_d     = state_q;
      fair_d      = fair_q;
      tmo_d       = tmo_q;
      mem_req_d   = o_mem_req;
      mem_we_d    = o_mem_we;
      mem_addr_d  = o_mem_addr;
      mem_wdata_d = o_mem_wdata;
      mem_be_d    = o_mem_be;
      if_ack_d    = 1'b0;
      if_err_d    = 1'b0;
      if_rdata_d  = '0;
      dm_ack_d    = 1'b0;
      dm_err_d    = 1'b0;
      dm_rdata_d  = '0;
      done        = 1'b0;
      done_data   = '0;

      unique case (state_q)
         IDLE: begin
            if (if_elig && (!dm_elig || fair_full)) begin
               state_d     = BUSY_IF;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b0;
               mem_addr_d  = i_if_addr;
               mem_wdata_d = '0;
               mem_be_d    = '1;
               tmo_d       = '0;
               fair_d      = '0;
            end else if (dm_elig) begin
               state_d     = BUSY_DM;
               mem_req_d   = 1'b1;
               mem_we_d    = i_dm_we;
               mem_addr_d  = i_dm_addr;
               mem_wdata_d = i_dm_wdata;
               mem_be_d    = i_dm_be;
               tmo_d       = '0;
               if (i_if_req && !fair_full)
                  fair_d = fair_q + FC_W'(1);
            end
         end
         BUSY_IF, BUSY_DM: begin
            if (i_mem_ack) begin
               done      = 1'b1;
               done_data = o_mem_we ? '0 : i_mem_rdata;
            end else if (tmo_hit) begin
               done      = 1'b1;
            end else begin
               tmo_d     = tmo_q + TC_W'(1);
            end
            if (done) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
               if (state_q == BUSY_IF) begin
                  if_ack_d   = 1'b1;
                  if_rdata_d = done_data;
                  if_err_d   = ~i_mem_ack;
               end else begin
                  dm_ack_d   = 1'b1;
                  dm_rdata_d = done_data;
                  dm_err_d   = ~i_mem_ack;
               end
            end
         end
         default: begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
         end
      endcase

      if (!i_if_req)
         fair_d = '0;
   end

   // State, counters and every registered output.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= IDLE;
         fair_q      <= '0;
         tmo_q       <= '0;
         o_mem_req   <= 1'b0;
         o_mem_we    <= 1'b0;
         o_mem_addr  <= '0;
         o_mem_wdata <= '0;
         o_mem_be    <= '0;
         o_if_ack    <= 1'b0;
         o_if_rdata  <= '0;
         o_if_err    <= 1'b0;
         o_dm_ack    <= 1'b0;
         o_dm_rdata  <= '0;
         o_dm_err    <= 1'b0;
      end else begin
         state_q     <= state_d;
         fair_q      <= fair_d;
         tmo_q       <= tmo_d;
         o_mem_req   <= mem_req_d;
         o_mem_we    <= mem_we_d;
         o_mem_addr  <= mem_addr_d;
         o_mem_wdata <= mem_wdata_d;
         o_mem_be    <= mem_be_d;
         o_if_ack    <= if_ack_d;
         o_if_rdata  <= if_rdata_d;
         o_if_err    <= if_err_d;
         o_dm_ack    <= dm_ack_d;
         o_dm_rdata  <= dm_rdata_d;
         o_dm_err    <= dm_err_d;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: grants, priority, fairness,
// fence blocking, timeout abort and asynchronous reset.
module tb_mem_port_arbiter;

   logic        clk;
   logic        rst_n;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_ack;
   logic [31:0] if_rdata;
   logic        if_err;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [3:0]  dm_be;
   logic        dm_ack;
   logic [31:0] dm_rdata;
   logic        dm_err;
   logic        fence;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        stall_if;
   logic        stall_dm;

   int checks;
   int failures;

   mem_port_arbiter #(
      .ADDR_W(32), .DATA_W(32), .FAIR_LIMIT(4), .TIMEOUT_CYC(255)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_if_req(if_req), .i_if_addr(if_addr),
      .o_if_ack(if_ack), .o_if_rdata(if_rdata), .o_if_err(if_err),
      .i_dm_req(dm_req), .i_dm_we(dm_we), .i_dm_addr(dm_addr),
      .i_dm_wdata(dm_wdata), .i_dm_be(dm_be),
      .o_dm_ack(dm_ack), .o_dm_rdata(dm_rdata), .o_dm_err(dm_err),
      .i_fence(fence),
      .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
      .o_mem_wdata(mem_wdata), .o_mem_be(mem_be),
      .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata),
      .o_stall_if(stall_if), .o_stall_dm(stall_dm)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic dm_txn(input logic [31:0] a);
      dm_req  = 1'b1;
      dm_we   = 1'b0;
      dm_addr = a;
      tick();
      chk("fdm_grant", 32'(mem_req), 32'd1);
      chk("fdm_addr", mem_addr, a);
      mem_ack   = 1'b1;
      mem_rdata = a ^ 32'h5a5a0000;
      tick();
      chk("fdm_ack", 32'(dm_ack), 32'd1);
      chk("fdm_rdata", dm_rdata, a ^ 32'h5a5a0000);
      mem_ack = 1'b0;
      dm_req  = 1'b0;
      tick();
   endtask

   initial begin
      checks = 0;
      failures = 0;
      rst_n = 1'b1;
      if_req = 0; if_addr = 0;
      dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0; dm_be = 0;
      fence = 0; mem_ack = 0; mem_rdata = 0;
      #2 rst_n = 1'b0;
      tick();
      tick();
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_be", 32'(mem_be), 32'd0);
      chk("rst_if_ack", 32'(if_ack), 32'd0);
      chk("rst_dm_ack", 32'(dm_ack), 32'd0);
      chk("rst_stall_if", 32'(stall_if), 32'd0);
      rst_n = 1'b1;
      tick();

      // memory ack while idle is ignored
      mem_ack = 1'b1; mem_rdata = 32'h13579bdf;
      tick();
      tick();
      chk("idle_ack_if", 32'(if_ack), 32'd0);
      chk("idle_ack_dm", 32'(dm_ack), 32'd0);
      chk("idle_ack_req", 32'(mem_req), 32'd0);
      mem_ack = 1'b0;

      // 1: single IF read
      if_req = 1'b1; if_addr = 32'h100;
      #1 chk("t1_stall_pre", 32'(stall_if), 32'd1);
      tick();
      chk("t1_req", 32'(mem_req), 32'd1);
      chk("t1_addr", mem_addr, 32'h100);
      chk("t1_we", 32'(mem_we), 32'd0);
      chk("t1_be", 32'(mem_be), 32'hf);
      tick();
      chk("t1_req_hold", 32'(mem_req), 32'd1);
      chk("t1_no_ack", 32'(if_ack), 32'd0);
      mem_ack = 1'b1; mem_rdata = 32'hdeadbeef;
      tick();
      chk("t1_ack", 32'(if_ack), 32'd1);
      chk("t1_rdata", if_rdata, 32'hdeadbeef);
      chk("t1_err", 32'(if_err), 32'd0);
      chk("t1_req_drop", 32'(mem_req), 32'd0);
      chk("t1_stall_ack", 32'(stall_if), 32'd0);
      mem_ack = 1'b0; if_req = 1'b0;
      tick();
      chk("t1_pulse", 32'(if_ack), 32'd0);

      // 2: simultaneous IF and DM store, DM first, IF back-to-back
      if_req = 1'b1; if_addr = 32'h140;
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200;
      dm_wdata = 32'h12345678; dm_be = 4'h3;
      tick();
      chk("t2_dm_addr", mem_addr, 32'h200);
      chk("t2_dm_we", 32'(mem_we), 32'd1);
      chk("t2_dm_wdata", mem_wdata, 32'h12345678);
      chk("t2_dm_be", 32'(mem_be), 32'h3);
      chk("t2_stall_dm", 32'(stall_dm), 32'd1);
      mem_ack = 1'b1; mem_rdata = 32'haaaa5555;
      tick();
      chk("t2_dm_ack", 32'(dm_ack), 32'd1);
      chk("t2_dm_rdata", dm_rdata, 32'd0);
      chk("t2_dm_err", 32'(dm_err), 32'd0);
      chk("t2_idle_req", 32'(mem_req), 32'd0);
      mem_ack = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
      tick();
      chk("t2_if_req", 32'(mem_req), 32'd1);
      chk("t2_if_addr", mem_addr, 32'h140);
      chk("t2_if_be", 32'(mem_be), 32'hf);
      chk("t2_if_we", 32'(mem_we), 32'd0);
      mem_ack = 1'b1; mem_rdata = 32'h11112222;
      tick();
      chk("t2_if_ack", 32'(if_ack), 32'd1);
      chk("t2_if_rdata", if_rdata, 32'h11112222);
      mem_ack = 1'b0; if_req = 1'b0;
      tick();

      // 3a: three DM grants with IF pending: DM still wins
      if_req = 1'b1; if_addr = 32'h300; fence = 1'b1;
      for (int i = 0; i < 3; i++) dm_txn(32'h400 + 32'(i * 4));
      fence = 1'b0;
      dm_req = 1'b1; dm_addr = 32'h40c;
      tick();
      chk("t3a_dm_wins", mem_addr, 32'h40c);
      mem_ack = 1'b1; mem_rdata = 32'h0;
      tick();
      chk("t3a_dm_ack", 32'(dm_ack), 32'd1);
      mem_ack = 1'b0; dm_req = 1'b0;
      tick();
      chk("t3a_if_next", mem_addr, 32'h300);
      mem_ack = 1'b1;
      tick();
      chk("t3a_if_ack", 32'(if_ack), 32'd1);
      mem_ack = 1'b0; if_req = 1'b0;
      tick();

      // 3b: four DM grants with IF pending, then IF must win
      if_req = 1'b1; if_addr = 32'h500; fence = 1'b1;
      for (int i = 0; i < 4; i++) dm_txn(32'h600 + 32'(i * 4));
      fence = 1'b0;
      dm_req = 1'b1; dm_addr = 32'h610;
      tick();
      chk("t3b_if_wins", mem_addr, 32'h500);
      chk("t3b_if_we", 32'(mem_we), 32'd0);
      chk("t3b_stall_dm", 32'(stall_dm), 32'd1);
      mem_ack = 1'b1; mem_rdata = 32'h77778888;
      tick();
      chk("t3b_if_ack", 32'(if_ack), 32'd1);
      chk("t3b_if_rdata", if_rdata, 32'h77778888);
      mem_ack = 1'b0; if_req = 1'b0;
      tick();
      chk("t3b_dm_resume", mem_addr, 32'h610);
      chk("t3b_dm_req", 32'(mem_req), 32'd1);
      mem_ack = 1'b1; mem_rdata = 32'h99990000;
      tick();
      chk("t3b_dm_ack", 32'(dm_ack), 32'd1);
      chk("t3b_dm_rdata", dm_rdata, 32'h99990000);
      mem_ack = 1'b0; dm_req = 1'b0;
      tick();

      // 4: fence blocks IF; fetch in flight completes when fence rises
      fence = 1'b1; if_req = 1'b1; if_addr = 32'h700;
      for (int i = 0; i < 10; i++) tick();
      chk("t4_blocked", 32'(mem_req), 32'd0);
      chk("t4_stall", 32'(stall_if), 32'd1);
      fence = 1'b0;
      tick();
      chk("t4_grant", 32'(mem_req), 32'd1);
      chk("t4_addr", mem_addr, 32'h700);
      fence = 1'b1;
      mem_ack = 1'b1; mem_rdata = 32'h0f0f0f0f;
      tick();
      chk("t4_ack", 32'(if_ack), 32'd1);
      chk("t4_rdata", if_rdata, 32'h0f0f0f0f);
      mem_ack = 1'b0;
      tick();
      tick();
      chk("t4_refetch_blk", 32'(mem_req), 32'd0);
      if_req = 1'b0; fence = 1'b0;
      tick();

      // 5: DM load timeout, then ack on the timeout edge
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h800;
      mem_rdata = 32'hbad0bad0;
      tick();
      chk("t5_grant", 32'(mem_req), 32'd1);
      for (int i = 0; i < 254; i++) tick();
      chk("t5_req_254", 32'(mem_req), 32'd1);
      chk("t5_no_ack_yet", 32'(dm_ack), 32'd0);
      tick();
      chk("t5_req_drop", 32'(mem_req), 32'd0);
      chk("t5_ack", 32'(dm_ack), 32'd1);
      chk("t5_err", 32'(dm_err), 32'd1);
      chk("t5_rdata", dm_rdata, 32'd0);
      dm_req = 1'b0;
      tick();
      chk("t5_pulse", 32'(dm_ack), 32'd0);
      dm_req = 1'b1; dm_addr = 32'h900;
      tick();
      chk("t5b_grant", mem_addr, 32'h900);
      for (int i = 0; i < 254; i++) tick();
      mem_ack = 1'b1; mem_rdata = 32'hcafef00d;
      tick();
      chk("t5b_ack", 32'(dm_ack), 32'd1);
      chk("t5b_err", 32'(dm_err), 32'd0);
      chk("t5b_rdata", dm_rdata, 32'hcafef00d);
      mem_ack = 1'b0; dm_req = 1'b0;
      tick();

      // 6: asynchronous reset in BUSY_DM, then normal IF grant
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'ha00;
      dm_wdata = 32'h55aa55aa; dm_be = 4'hf;
      tick();
      chk("t6_busy", 32'(mem_req), 32'd1);
      #2 rst_n = 1'b0;
      #1 chk("t6_async_drop", 32'(mem_req), 32'd0);
      chk("t6_no_ack", 32'(dm_ack), 32'd0);
      dm_req = 1'b0; dm_we = 1'b0;
      if_req = 1'b1; if_addr = 32'hb00;
      tick();
      chk("t6_no_ack_rst", 32'(dm_ack), 32'd0);
      rst_n = 1'b1;
      tick();
      chk("t6_if_grant", 32'(mem_req), 32'd1);
      chk("t6_if_addr", mem_addr, 32'hb00);
      chk("t6_no_dm_ack", 32'(dm_ack), 32'd0);
      mem_ack = 1'b1; mem_rdata = 32'h600d600d;
      tick();
      chk("t6_if_ack", 32'(if_ack), 32'd1);
      chk("t6_if_rdata", if_rdata, 32'h600d600d);
      mem_ack = 1'b0; if_req = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
